decoder_10b_8b: RTL
===================

Name: decoder_10b_8b

Overview:
- Receive-side counterpart of the team's 8b/10b encoder.
- Accepts 10-bit symbols from the deserializer when des_en is high and maps them back to 8-bit data with one registered cycle of latency.
- Flags illegal symbols and runs a lock state machine, so downstream logic consumes data only while the link is trustworthy.
- Sits between the deserializer and the receive datapath.

Parameters:
- LOCK_CNT, 4: consecutive legal symbols needed to enter or remain locked.
- ERR_MAX, 3: illegal symbols, counted while LOCKED, that force a return to HUNT.
- ERR_CNT_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- data_10b_in  input  10  symbol; [9:6] is the 4b sub-block, [5:0] is the 6b sub-block.
- des_en  input  1  symbol-valid strobe, sampled every clk.
- data_8b_out  output  8  decoded byte.
- out_valid  output  1  one-cycle pulse per accepted symbol.
- code_err  output  1  qualifies out_valid; 1 means the symbol was illegal.
- locked  output  1  high while the FSM is in LOCKED.
- err_cnt  output  ERR_CNT_W  saturating count of illegal symbols.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - data_8b_out=0, out_valid=0, code_err=0, locked=0, err_cnt=0.
  - FSM=HUNT; both internal counters cleared.
  - Asserting rst_n=0 mid-stream clears everything immediately. The first symbol after release is treated as a fresh HUNT input.
- 6b table, data[4:0]=0..31 maps to these codes (hex): 18,1D,12,31,35,29,19,38,39,25,15,34,0D,2C,1C,17,1B,23,13,32,0B,2A,1A,3A,33,26,16,36,0E,2E,1E,2B.
- 4b table, data[7:5]=0..7 maps to these codes (hex): 4,9,5,3,2,A,6,1.
- Decoding: the block inverts both tables. A symbol is legal only if both sub-blocks appear in their tables.
- Latency:
  - A symbol sampled with des_en=1 at edge N produces out_valid=1 for exactly the cycle after edge N.
  - When des_en=0, out_valid=0 and data_8b_out/code_err hold their last values.
  - Back-to-back des_en gives one output per cycle with no bubbles.
- Illegal symbol: data_8b_out=8'h00, code_err=1.
  - Each sub-block is checked independently; either one failing makes the symbol illegal.
- FSM states (good_cnt and bad_cnt are internal):
  - HUNT:
    - Each legal symbol increments good_cnt; an illegal one clears it.
    - When good_cnt reaches LOCK_CNT, go to LOCKED with good_cnt=0 and bad_cnt=0.
    - locked rises in the cycle after the LOCK_CNT-th legal symbol is sampled, coincident with that symbol's out_valid.
  - LOCKED:
    - Each illegal symbol increments bad_cnt and clears good_cnt.
    - Each legal symbol increments good_cnt. When good_cnt reaches LOCK_CNT, bad_cnt and good_cnt both clear.
    - When bad_cnt reaches ERR_MAX, go to HUNT with counters cleared. locked falls coincident with that symbol's out_valid.
  - Cycles with des_en=0 never advance the FSM.
- Data is always emitted regardless of lock state; locked is advisory only.
- err_cnt:
  - Increments on every illegal accepted symbol, in any state.
  - Saturates at all-ones, with no wrap.

Optional Feature:
- Macro: DEC_ERR_CNT_EN.
- Defined: err_cnt behaves as described above.
- Undefined: the counter logic is not built and err_cnt is tied to 0. All other behaviour is unchanged.

Decomposition:
- Shared package enc_8b10b_pkg holds:
  - the 6b and 4b code-table constants, shared with the encoder;
  - decode functions that return {legal, value};
  - the FSM state typedef (HUNT, LOCKED).
- One sub-module, dec_lock_fsm, owns good_cnt, bad_cnt and locked. Its inputs are the strobe and the legal flag. The top level holds only the decode registers and err_cnt.

Test Plan:
- Reset, then des_en pulses with 0x118, 0x06B, 0x2A9 -> one cycle later each: data_8b_out = 0x00, 0xFF, 0xA5 respectively, code_err=0, one out_valid per symbol.
- Sweep all 256 bytes through the encoder tables back-to-back with des_en held high -> every output matches, no bubbles. locked=1 from the 4th output onward.
- While locked, inject 0x000 three times, interleaved with two legal symbols -> code_err=1 and data=0x00 on each illegal symbol. locked falls with the 3rd illegal symbol's out_valid. err_cnt=3 (DEC_ERR_CNT_EN defined) or 0 (undefined).
- While locked, inject 2 illegal symbols, then 4 legal, then 2 illegal -> locked stays 1 (bad_cnt cleared by the 4 legal symbols).
- Hold des_en=0 for 10 cycles mid-stream -> out_valid=0, outputs hold, FSM and counters frozen.
- Pull rst_n low asynchronously between clock edges during traffic -> all outputs 0 immediately. After release, 4 legal symbols are needed to relock.

Source files
------------

// File: rtl/enc_8b10b_pkg.sv
// Shared 8b/10b code tables, sub-block decode helpers and the receive lock-FSM state type.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package enc_8b10b_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

   // 6b sub-block code for data[4:0] = 0..31 (shared with the encoder)
   localparam logic [5:0] CODE_6B [32] = '{
      6'h18, 6'h1D, 6'h12, 6'h31, 6'h35, 6'h29, 6'h19, 6'h38,
      6'h39, 6'h25, 6'h15, 6'h34, 6'h0D, 6'h2C, 6'h1C, 6'h17,
      6'h1B, 6'h23, 6'h13, 6'h32, 6'h0B, 6'h2A, 6'h1A, 6'h3A,
      6'h33, 6'h26, 6'h16, 6'h36, 6'h0E, 6'h2E, 6'h1E, 6'h2B
   };

   // 4b sub-block code for data[7:5] = 0..7 (shared with the encoder)
   localparam logic [3:0] CODE_4B [8] = '{
      4'h4, 4'h9, 4'h5, 4'h3, 4'h2, 4'hA, 4'h6, 4'h1
   };

   // Inverse 6b lookup: {legal, data[4:0]}; value is 0 when the code is not in the table
   function automatic logic [5:0] decode_6b(input logic [5:0] code);
      logic [5:0] res;
      res = '0;
      for (int i = 0; i < 32; i++) begin
         if (CODE_6B[i] == code) begin
            res = {1'b1, 5'(i)};
         end
      end
      return res;
   endfunction

   // Inverse 4b lookup: {legal, data[7:5]}; value is 0 when the code is not in the table
   function automatic logic [3:0] decode_4b(input logic [3:0] code);
      logic [3:0] res;
      res = '0;
      for (int i = 0; i < 8; i++) begin
         if (CODE_4B[i] == code) begin
            res = {1'b1, 3'(i)};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dec_lock_fsm.sv
// Link lock tracker: HUNT until LOCK_CNT consecutive legal symbols, drop after ERR_MAX errors while LOCKED.
// Latency: locked updates on the edge that samples the deciding symbol (aligned with its decoded output).
// Backpressure: none; the FSM only advances on cycles where sym_vld is high.
module dec_lock_fsm
   import enc_8b10b_pkg::*;
#(
   parameter int LOCK_CNT = 4,
   parameter int ERR_MAX  = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sym_vld,
   input  logic sym_legal,
   output logic locked
);

   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int BAD_W  = $clog2(ERR_MAX + 1);

   lock_state_t       state_q, state_d;
   logic [GOOD_W-1:0] good_cnt_q, good_cnt_d, good_inc;
   logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d, bad_inc;

   // State and run-length counters, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         good_cnt_q <= '0;
         bad_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         good_cnt_q <= good_cnt_d;
         bad_cnt_q  <= bad_cnt_d;
      end
   end

   // Next-state: idle cycles hold everything; a full run of legal symbols also forgives past errors
   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      bad_cnt_d  = bad_cnt_q;
      good_inc   = good_cnt_q + GOOD_W'(1);
      bad_inc    = bad_cnt_q + BAD_W'(1);
      if (sym_vld) begin
         case (state_q)
            HUNT: begin
               if (sym_legal) begin
                  if (good_inc == GOOD_W'(LOCK_CNT)) begin
                     state_d    = LOCKED;
                     good_cnt_d = '0;
                     bad_cnt_d  = '0;
                  end else begin
                     good_cnt_d = good_inc;
                  end
               end else begin
                  good_cnt_d = '0;
               end
            end
            LOCKED: begin
               if (sym_legal) begin
                  if (good_inc == GOOD_W'(LOCK_CNT)) begin
                     good_cnt_d = '0;
                     bad_cnt_d  = '0;
                  end else begin
                     good_cnt_d = good_inc;
                  end
               end else begin
                  good_cnt_d = '0;
                  if (bad_inc == BAD_W'(ERR_MAX)) begin
                     state_d   = HUNT;
                     bad_cnt_d = '0;
                  end else begin
                     bad_cnt_d = bad_inc;
                  end
               end
            end
            default: begin
               state_d    = HUNT;
               good_cnt_d = '0;
               bad_cnt_d  = '0;
            end
         endcase
      end
   end

   assign locked = (state_q == LOCKED);

endmodule

// File: rtl/decoder_10b_8b.sv
// 10b->8b symbol decoder with illegal-symbol flag, lock tracking and saturating error count (DEC_ERR_CNT_EN).
// Latency: one cycle; a symbol sampled with des_en=1 yields out_valid on the following cycle.
// Backpressure: none; one symbol per cycle accepted, outputs hold their last value while des_en=0.
module decoder_10b_8b
   import enc_8b10b_pkg::*;
#(
   parameter int LOCK_CNT  = 4,
   parameter int ERR_MAX   = 3,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [9:0]           data_10b_in,
   input  logic                 des_en,
   output logic [7:0]           data_8b_out,
   output logic                 out_valid,
   output logic                 code_err,
   output logic                 locked,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic [5:0] dec_6b;
   logic [3:0] dec_4b;
   logic       sym_legal;
   logic [7:0] sym_byte;

   // Table lookup of both sub-blocks; an illegal symbol decodes to 0x00
   always_comb begin
      dec_6b    = decode_6b(data_10b_in[5:0]);
      dec_4b    = decode_4b(data_10b_in[9:6]);
      sym_legal = dec_6b[5] & dec_4b[3];
      sym_byte  = sym_legal ? {dec_4b[2:0], dec_6b[4:0]} : 8'h00;
   end

   // Output register: pulse valid per accepted symbol, hold data and flag between symbols
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_8b_out <= 8'h00;
         out_valid   <= 1'b0;
         code_err    <= 1'b0;
      end else begin
         out_valid <= des_en;
         if (des_en) begin
            data_8b_out <= sym_byte;
            code_err    <= ~sym_legal;
         end
      end
   end

`ifdef DEC_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q;

   // Count illegal accepted symbols in any lock state, sticking at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else if (des_en && !sym_legal && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

   dec_lock_fsm #(
      .LOCK_CNT (LOCK_CNT),
      .ERR_MAX  (ERR_MAX)
   ) u_lock_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .sym_vld   (des_en),
      .sym_legal (sym_legal),
      .locked    (locked)
   );

endmodule
